dac_instr_queue: RTL and testbench

DAC_INSTR_QUEUE -- requirements
Module: dac_instr_queue

---
 rtl/dac_instr_queue_pkg.sv | 35 +++
 rtl/dac_instr_queue_if.sv | 29 ++
 rtl/dac_frame_shifter.sv | 88 ++++++++
 rtl/dac_instr_queue.sv | 144 ++++++++++++++
 tb/tb_dac_instr_queue.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/dac_instr_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_instr_queue_pkg
// Purpose  : Shared frame layout, DAC command codes, FSM encoding and the
//            frame-building helper for the DAC instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
package dac_instr_queue_pkg;

    localparam int C_FRAME_W = 32;
    localparam int C_W_ADDR  = 4;
    localparam int C_W_FDATA = 16;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_INT_REF      = 4'b1000;

    // Internal reference power-up frame
    localparam logic [C_FRAME_W-1:0] C_INIT_FRAME = {4'b0000, CMD_INT_REF, 24'h00_0001};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic logic [C_FRAME_W-1:0] build_frame(
        input logic [C_W_ADDR-1:0]  addr,
        input logic [C_W_FDATA-1:0] data
    );
        return {4'b0000, CMD_WRITE_UPDATE, addr, data, 4'b0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_instr_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_instr_queue_if
// Purpose  : Channel-word input bus and DAC serial/status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface dac_instr_queue_if #(
    parameter int N_CHAN = 8,
    parameter int W_DATA = 16
);
    logic [N_CHAN*W_DATA-1:0] data_in;
    logic [N_CHAN-1:0]        data_valid_in;
    logic                     dac_sclk_out;
    logic                     dac_sync_n_out;
    logic                     dac_din_out;
    logic                     frame_done_out;
    logic                     busy_out;

    modport master (
        output data_in, data_valid_in,
        input  dac_sclk_out, dac_sync_n_out, dac_din_out, frame_done_out, busy_out
    );

    modport slave (
        input  data_in, data_valid_in,
        output dac_sclk_out, dac_sync_n_out, dac_din_out, frame_done_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/dac_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module   : dac_frame_shifter
// Purpose  : Serialises one 32-bit frame MSB first; data changes on SCLK
//            rising edges so the DAC samples on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module dac_frame_shifter
    import dac_instr_queue_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  wire logic                 clk_in,
    input  wire logic                 reset_in,
    input  wire logic                 load,
    input  wire logic [C_FRAME_W-1:0] frame,
    output logic                      dac_sclk_out,
    output logic                      dac_sync_n_out,
    output logic                      dac_din_out,
    output logic                      done,
    output logic                      last
);
    localparam int                W_DIV       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [W_DIV-1:0]  C_DIV_MAX   = W_DIV'(SCLK_DIV - 1);
    localparam int                W_HALF      = $clog2(2 * C_FRAME_W);
    localparam logic [W_HALF-1:0] C_LAST_HALF = W_HALF'(2 * C_FRAME_W - 1);

    logic                 r_active;
    logic [W_DIV-1:0]     r_div;
    logic [W_HALF-1:0]    r_half;
    logic [C_FRAME_W-1:0] r_sr;
    logic                 r_sclk;
    logic                 r_sync_n;
    logic                 r_done;
    logic                 w_tick;

    assign w_tick = r_active && (r_div == C_DIV_MAX);
    // Combinational so the controller leaves SHIFT in the same edge the frame closes
    assign last   = w_tick && (r_half == C_LAST_HALF);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_half   <= '0;
            r_sr     <= '0;
            r_sclk   <= 1'b1;
            r_sync_n <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_active <= 1'b1;
                r_div    <= '0;
                r_half   <= '0;
                r_sr     <= frame;
                r_sclk   <= 1'b1;
                r_sync_n <= 1'b0;
            end else if (r_active) begin
                if (w_tick) begin
                    r_div <= '0;
                    if (last) begin
                        r_active <= 1'b0;
                        r_sr     <= '0;
                        r_sclk   <= 1'b1;
                        r_sync_n <= 1'b1;
                        r_done   <= 1'b1;
                    end else begin
                        r_half <= r_half + 1'b1;
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_sr <= {r_sr[C_FRAME_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign dac_sclk_out   = r_sclk;
    assign dac_sync_n_out = r_sync_n;
    assign dac_din_out    = r_sr[C_FRAME_W-1];
    assign done           = r_done;

endmodule
`default_nettype wire

// File: rtl/dac_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : dac_instr_queue
// Purpose  : Latches per-channel words, services them round-robin and sends
//            each as a DAC write-and-update frame.
//            Optional DAC_INIT_SEQ_EN: one internal-reference frame after reset.
// Revision : 1.0 - initial release
// ============================================================================
module dac_instr_queue
    import dac_instr_queue_pkg::*;
#(
    parameter int N_CHAN   = 8,
    parameter int W_DATA   = 16,
    parameter int SCLK_DIV = 2,
    parameter int SYNC_GAP = 2
) (
    input  wire logic        clk_in,
    input  wire logic        reset_in,
    dac_instr_queue_if.slave bus
);
    localparam int                W_IDX     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int                W_GAP     = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [W_GAP-1:0]  C_GAP_MAX = W_GAP'(SYNC_GAP - 1);
    localparam logic [W_IDX:0]    C_N_CHAN  = (W_IDX + 1)'(N_CHAN);

    state_t               r_state, w_state_next;
    logic [N_CHAN-1:0]    r_pending;
    logic [W_DATA-1:0]    r_word [N_CHAN];
    logic [W_IDX-1:0]     r_ptr, w_sel, w_sel_next;
    logic [W_IDX:0]       w_idx;
    logic                 w_found;
    logic [W_GAP-1:0]     r_gap;
    logic                 w_init_req, w_load, w_take;
    logic [W_DATA-1:0]    w_word;
    logic [C_W_FDATA-1:0] w_word16, w_ob;
    logic [C_FRAME_W-1:0] w_frame;
    logic                 w_last, w_done, w_sclk, w_sync_n, w_din;

`ifdef DAC_INIT_SEQ_EN
    logic r_init_req;
    always_ff @(posedge clk_in) begin
        if (reset_in)    r_init_req <= 1'b1;
        else if (w_load) r_init_req <= 1'b0;
    end
    assign w_init_req = r_init_req;
`else
    assign w_init_req = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Incoming strobes are looked at directly in IDLE to reach SHIFT two cycles after a strobe
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_init_req || (|(r_pending | bus.data_valid_in))) w_state_next = ST_LOAD;
            ST_LOAD:  begin
                w_load       = 1'b1;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: if (w_last) w_state_next = ST_GAP;
            ST_GAP:   if (r_gap == C_GAP_MAX) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_take = w_load && !w_init_req;

    // Round-robin: first pending channel at or after the pointer
    always_comb begin
        w_sel   = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            w_idx = {1'b0, r_ptr} + (W_IDX + 1)'(i);
            if (w_idx >= C_N_CHAN) w_idx = w_idx - C_N_CHAN;
            if (!w_found && r_pending[w_idx[W_IDX-1:0]]) begin
                w_sel   = w_idx[W_IDX-1:0];
                w_found = 1'b1;
            end
        end
        w_sel_next = (w_sel == W_IDX'(N_CHAN - 1)) ? '0 : w_sel + 1'b1;
    end

    assign w_word = r_word[w_sel];

    generate
        if (W_DATA >= C_W_FDATA) begin : g_trunc
            assign w_word16 = w_word[W_DATA-1 -: C_W_FDATA];
        end else begin : g_sext
            assign w_word16 = {{(C_W_FDATA - W_DATA){w_word[W_DATA-1]}}, w_word};
        end
    endgenerate

    assign w_ob    = {~w_word16[C_W_FDATA-1], w_word16[C_W_FDATA-2:0]};
    assign w_frame = w_init_req ? C_INIT_FRAME : build_frame(C_W_ADDR'(w_sel), w_ob);

    // A strobe in the LOAD cycle keeps the channel pending with the newer word
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_pending <= '0;
            r_ptr     <= '0;
            r_gap     <= '0;
            for (int k = 0; k < N_CHAN; k++) r_word[k] <= '0;
        end else begin
            r_gap <= (r_state == ST_GAP) ? r_gap + 1'b1 : '0;
            if (w_take) r_ptr <= w_sel_next;
            for (int k = 0; k < N_CHAN; k++) begin
                if (bus.data_valid_in[k]) begin
                    r_pending[k] <= 1'b1;
                    r_word[k]    <= bus.data_in[k*W_DATA +: W_DATA];
                end else if (w_take && (w_sel == W_IDX'(k))) begin
                    r_pending[k] <= 1'b0;
                end
            end
        end
    end

    dac_frame_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .load           (w_load),
        .frame          (w_frame),
        .dac_sclk_out   (w_sclk),
        .dac_sync_n_out (w_sync_n),
        .dac_din_out    (w_din),
        .done           (w_done),
        .last           (w_last)
    );

    assign bus.dac_sclk_out   = w_sclk;
    assign bus.dac_sync_n_out = w_sync_n;
    assign bus.dac_din_out    = w_din;
    assign bus.frame_done_out = w_done;
    assign bus.busy_out       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dac_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_instr_queue
// Purpose  : Self-checking bench; frames are deserialised from the DAC pins
//            and compared against a queue of expected frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_instr_queue;
    localparam int N_CHAN    = 8;
    localparam int W_DATA    = 16;
    localparam int SCLK_DIV  = 2;
    localparam int SYNC_GAP  = 2;
    localparam int FRAME_CYC = 64 * SCLK_DIV;
`ifdef DAC_INIT_SEQ_EN
    localparam int INIT_FRAMES = 1;
`else
    localparam int INIT_FRAMES = 0;
`endif
    localparam logic [31:0] INIT_WORD = 32'h0800_0001;

    logic clk_in = 1'b0;
    logic reset_in;

    dac_instr_queue_if #(.N_CHAN(N_CHAN), .W_DATA(W_DATA)) bus ();

    dac_instr_queue #(
        .N_CHAN   (N_CHAN),
        .W_DATA   (W_DATA),
        .SCLK_DIV (SCLK_DIV),
        .SYNC_GAP (SYNC_GAP)
    ) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    int          cyc = 0, done_cnt = 0, frames = 0, aborted = 0, bitcnt = 0;
    int          last_hi = 0, fall_cyc = 0, rise_cyc = 0;
    logic [31:0] shreg = '0;
    logic        prev_sync = 1'b1, prev_sclk = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pin-level deserialiser: a bit is taken on each SCLK fall while SYNC_N is low
    always @(posedge clk_in) begin
        #1;
        cyc++;
        if (bus.frame_done_out) done_cnt++;
        if (prev_sync && !bus.dac_sync_n_out) begin
            bitcnt   = 0;
            shreg    = '0;
            fall_cyc = cyc;
            last_hi  = cyc - rise_cyc;
        end
        if (!bus.dac_sync_n_out && prev_sclk && !bus.dac_sclk_out) begin
            shreg = {shreg[30:0], bus.dac_din_out};
            bitcnt++;
        end
        if (!prev_sync && bus.dac_sync_n_out) begin
            rise_cyc = cyc;
            if (bitcnt == 32) begin
                frames++;
                check("frame_done_at_end", 32'(bus.frame_done_out), 32'd1);
                check("frame_len", 32'(cyc - fall_cyc), 32'(FRAME_CYC));
                check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("frame_data", shreg, exp_q.pop_front());
            end else begin
                aborted++;
            end
        end
        prev_sync = bus.dac_sync_n_out;
        prev_sclk = bus.dac_sclk_out;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobe(input int ch, input logic [15:0] d);
        bus.data_in[ch*W_DATA +: W_DATA] = d;
        bus.data_valid_in                = '0;
        bus.data_valid_in[ch]            = 1'b1;
        tick();
        bus.data_valid_in = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.busy_out || exp_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check(name, 32'(n < 3000), 32'd1);
        tick();
    endtask

    typedef struct {
        int          ch;
        logic [15:0] data;
        logic [31:0] exp_frame;
    } vec_t;

    vec_t vecs[7];
    int   lat, d0, f0, a0, n;

    initial begin
        vecs[0] = '{3, 16'h0000, 32'h0338_0000};
        vecs[1] = '{0, 16'h7FFF, 32'h030F_FFF0};
        vecs[2] = '{5, 16'h8000, 32'h0350_0000};
        vecs[3] = '{7, 16'h0001, 32'h0378_0010};
        vecs[4] = '{1, 16'hFFFF, 32'h0317_FFF0};
        vecs[5] = '{6, 16'h1234, 32'h0369_2340};
        vecs[6] = '{2, 16'h5678, 32'h032D_6780};

        reset_in          = 1'b1;
        bus.data_in       = '0;
        bus.data_valid_in = '0;
        repeat (3) tick();
        check("rst_sync_n", 32'(bus.dac_sync_n_out), 32'd1);
        check("rst_sclk",   32'(bus.dac_sclk_out),   32'd1);
        check("rst_din",    32'(bus.dac_din_out),    32'd0);
        check("rst_done",   32'(bus.frame_done_out), 32'd0);
        check("rst_busy",   32'(bus.busy_out),       32'd0);
        if (INIT_FRAMES != 0) exp_q.push_back(INIT_WORD);
        reset_in = 1'b0;
        wait_idle("init_idle");

        // Simultaneous strobes on channels 2 and 6 with the pointer at 0
        d0 = done_cnt;
        exp_q.push_back(32'h0328_1000);
        exp_q.push_back(32'h0367_F000);
        bus.data_in[2*W_DATA +: W_DATA] = 16'h0100;
        bus.data_in[6*W_DATA +: W_DATA] = 16'hFF00;
        bus.data_valid_in               = 8'b0100_0100;
        tick();
        bus.data_valid_in = '0;
        wait_idle("pair_idle");
        check("pair_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("pair_sync_gap", 32'(last_hi >= SYNC_GAP && last_hi <= SYNC_GAP + 2), 32'd1);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vecs[i].exp_frame);
            strobe(vecs[i].ch, vecs[i].data);
            lat = 1;
            while (bus.dac_sync_n_out && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("latency_ch%0d", vecs[i].ch), 32'(lat), 32'd2);
            wait_idle("vec_idle");
        end

        // Pointer now at 3: channel 7 must precede channel 0
        exp_q.push_back(32'h0374_0000);
        exp_q.push_back(32'h0308_0100);
        bus.data_in[0*W_DATA +: W_DATA] = 16'h0010;
        bus.data_in[7*W_DATA +: W_DATA] = 16'hC000;
        bus.data_valid_in               = 8'b1000_0001;
        tick();
        bus.data_valid_in = '0;
        wait_idle("rr_idle");

        // Latest word wins while another channel shifts
        f0 = frames;
        exp_q.push_back(32'h031C_0000);
        strobe(1, 16'h4000);
        repeat (20) tick();
        strobe(4, 16'h1234);
        repeat (5) tick();
        strobe(4, 16'h5678);
        exp_q.push_back(32'h034D_6780);
        wait_idle("overwrite_idle");
        check("overwrite_frames", 32'(frames - f0), 32'd2);

        // Reset mid-frame with another channel pending
        strobe(3, 16'h1111);
        strobe(5, 16'h2222);
        n = 0;
        while (bitcnt < 10 && n < 500) begin
            tick();
            n++;
        end
        check("reach_bit10", 32'(n < 500), 32'd1);
        d0 = done_cnt;
        f0 = frames;
        a0 = aborted;
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check("abort_sync_high", 32'(bus.dac_sync_n_out), 32'd1);
        check("abort_busy_low",  32'(bus.busy_out),       32'd0);
        if (INIT_FRAMES != 0) exp_q.push_back(INIT_WORD);
        repeat (400) tick();
        check("abort_done_pulses", 32'(done_cnt - d0), 32'(INIT_FRAMES));
        check("abort_no_frames",   32'(frames - f0),   32'(INIT_FRAMES));
        check("abort_counted",     32'(aborted - a0),  32'd1);
        check("queue_drained",     32'(exp_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
